video_timing_gen: RTL
=====================

# video_timing_gen

Parametrised LCD/RGB timing generator with frame lock and FIFO read-out, replacing the fixed-timing pixel path between the camera line FIFO and the LCD pins. It generates hs/vs/de from programmable porch parameters and re-locks its counters to an upstream frame-start pulse after a programmable prefill delay. It reads pixels from the read side of a normal-mode (1-cycle latency) FIFO, and substitutes a fill colour on underflow or a test pattern on request. Single clock domain; `frame_start` is synchronised to `video_clk` upstream.

## Interface
Parameters:
- `DATA_WIDTH`, 16: pixel width.
- `H_ACTIVE` / `H_FP` / `H_SYNC` / `H_BP`, 480 / 2 / 41 / 2: horizontal timing, in clocks.
- `V_ACTIVE` / `V_FP` / `V_SYNC` / `V_BP`, 272 / 2 / 10 / 2: vertical timing, in lines.
- `HS_POL` / `VS_POL`, 0 / 0: active level of the sync pulses.
- `LOCK_EN`, 1: 1 = wait for and lock to `frame_start`; 0 = free-run from reset.
- `LOCK_DELAY`, 550: clocks between an accepted `frame_start` and counter restart. 0 is legal.
- `FILL_COLOR`, 0: pixel value driven on underflow.
- `CNT_W`, 12: counter width. H and V totals must each be ≤ 2^CNT_W − 1.

Ports:
- `video_clk` in 1: pixel clock.
- `video_rst` in 1: synchronous reset, active-high.
- `frame_start` in 1: single-cycle pulse marking the upstream frame start.
- `pattern_en` in 1: 1 = drive the test pattern and do not read the FIFO. Sampled per pixel.
- `fifo_q` in DATA_WIDTH: FIFO read data, valid one cycle after `fifo_rd_en`.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_en` out 1: FIFO read request, combinational from stage-0 registers.
- `hs`, `vs`, `de` out 1: registered timing outputs.
- `vout_data` out DATA_WIDTH: registered pixel, aligned with `de`.
- `x`, `y` out CNT_W: active-area coordinates, aligned with `de`; 0 outside the active area.
- `underflow` out 1: sticky flag, set when a pixel was due while the FIFO was empty.
- `locked` out 1: high while in RUN.

## Operation
- Stage 0 holds counters `h_cnt` 0..H_TOTAL−1 and `v_cnt` 0..V_TOTAL−1, where H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL likewise.
- Segment order within a line or frame: sync, back porch, active, front porch, each starting at count 0.
- Counter update: `h_cnt` wraps at H_TOTAL−1. `v_cnt` increments only on an `h_cnt` wrap and wraps at V_TOTAL−1.
- Stage-0 signals:
  - hs0 = (h_cnt < H_SYNC).
  - vs0 = (v_cnt < V_SYNC).
  - de0 = both counters inside active AND state == RUN.
- State machine:
  - IDLE: counters held at 0; no sync or de.
  - DELAY: delay counter runs; counters held at 0.
  - RUN: counters advance.
- Transitions:
  - Reset → IDLE if LOCK_EN, else RUN.
  - IDLE + `frame_start` → DELAY, or directly to RUN if LOCK_DELAY = 0.
  - DELAY → RUN once the delay counter reaches LOCK_DELAY−1.
  - `frame_start` in DELAY restarts the delay count.
  - `frame_start` in RUN (LOCK_EN = 1) → DELAY with counters zeroed, or, if LOCK_DELAY = 0, counters zeroed and RUN kept. The current frame is truncated.
  - With LOCK_EN = 0, `frame_start` is ignored.
- In IDLE/DELAY, hs and vs are held at their inactive levels and de = 0.
- fifo_rd_en = de0 & !pattern_en & !fifo_empty.
- Stage-1 pixel mux, on the cycle after de0:
  - de & pattern → (x + y) mod 2^DATA_WIDTH.
  - de & a read was issued → `fifo_q`.
  - de & no read (FIFO empty) → FILL_COLOR, and `underflow` is set.
  - !de → 0.
- `underflow` clears on reset and when a `frame_start` is accepted (LOCK_EN = 1). Set takes priority on the same cycle.
- Reset mid-frame: every output returns to its reset value on the next edge. No FIFO read is issued in the reset cycle's aftermath.

## Timing
- Reset values:
  - hs = ~HS_POL, vs = ~VS_POL.
  - de = 0, vout_data = 0, x = 0, y = 0.
  - fifo_rd_en = 0, underflow = 0.
  - locked = 0 if LOCK_EN, else 1.
- Pipeline latency is 1 clock: hs, vs, de, x, y and vout_data are stage-0 values registered once. The FIFO data for a read issued at cycle t appears on `vout_data` at t+1, with de = 1.
- Lock timing: `frame_start` accepted at cycle t → stage-0 counter (0,0) in RUN at t+1+LOCK_DELAY → first hs/vs output edge at t+2+LOCK_DELAY.
- Frame period: exactly H_TOTAL×V_TOTAL clocks in RUN without intervening `frame_start`.
- `pattern_en` changes take effect on the next pixel and never glitch `fifo_rd_en` outside de0.

## Test plan
Bench parameters: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), LOCK_DELAY 3, polarities 0.

1. Free-run (LOCK_EN = 0): release reset → hs low for 2 clocks every 14 clocks; vs low for 14 clocks every 98 clocks; de high 8 clocks per line on lines 2..5; 32 de cycles per frame.
2. Lock: `frame_start` at cycle 10 → `locked` rises at cycle 14; first hs low at cycle 15; no de or fifo_rd_en before then.
3. FIFO path: prefilled FIFO holding 0x0001..0x0020 → `vout_data` equals 1..32 in order on de cycles; exactly 32 `fifo_rd_en` pulses; `underflow` stays 0.
4. Underflow: `fifo_empty` forced high for the 3rd pixel of line 1 → `vout_data` = FILL_COLOR on that pixel; no read issued; `underflow` = 1 until the next accepted `frame_start`.
5. Pattern and re-lock:
   - `pattern_en` = 1 → `vout_data` = x+y (row 1: 1..8) with no FIFO reads.
   - `frame_start` mid-active → de drops on the next edge; counters restart 3 clocks later.
   - `video_rst` pulse mid-frame → all outputs return to their reset values.

Source files
------------

// File: rtl/video_timing_gen.sv
// LCD/RGB timing generator: hs/vs/de from programmable porches, optional lock
// to an upstream frame start, and FIFO or test-pattern pixel read-out.
module video_timing_gen #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    H_ACTIVE   = 480,
  parameter int                    H_FP       = 2,
  parameter int                    H_SYNC     = 41,
  parameter int                    H_BP       = 2,
  parameter int                    V_ACTIVE   = 272,
  parameter int                    V_FP       = 2,
  parameter int                    V_SYNC     = 10,
  parameter int                    V_BP       = 2,
  parameter logic                  HS_POL     = 1'b0,
  parameter logic                  VS_POL     = 1'b0,
  parameter logic                  LOCK_EN    = 1'b1,
  parameter int                    LOCK_DELAY = 550,
  parameter logic [DATA_WIDTH-1:0] FILL_COLOR = {DATA_WIDTH{1'b0}},
  parameter int                    CNT_W      = 12
) (
  input  logic                  video_clk,
  input  logic                  video_rst,
  input  logic                  frame_start,
  input  logic                  pattern_en,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  hs,
  output logic                  vs,
  output logic                  de,
  output logic [DATA_WIDTH-1:0] vout_data,
  output logic [CNT_W-1:0]      x,
  output logic [CNT_W-1:0]      y,
  output logic                  underflow,
  output logic                  locked
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int DLY_W   = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
  localparam int SUM_W   = (DATA_WIDTH > CNT_W + 1) ? DATA_WIDTH : CNT_W + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_E  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_E  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_B   = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_E   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_B   = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_E   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [DLY_W-1:0] DLY_ZERO  = {DLY_W{1'b0}};
  localparam logic [DLY_W-1:0] DLY_ONE   = DLY_W'(1);
  localparam logic [DLY_W-1:0] DLY_LAST  = DLY_W'((LOCK_DELAY > 0) ? LOCK_DELAY - 1 : 0);
  localparam logic [DATA_WIDTH-1:0] PIX_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam state_t ST_RESET = (LOCK_EN == 1'b1) ? ST_IDLE : ST_RUN;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  h_cnt_r, h_cnt_s, v_cnt_r, v_cnt_s;
  logic [DLY_W-1:0]  dly_cnt_r, dly_cnt_s;
  logic              fs_acc_s, run_s, h_act_s, v_act_s, hs0_s, vs0_s, de0_s;
  logic [CNT_W-1:0]  x0_s, y0_s;
  logic              pat_r, rd_r;
  logic [SUM_W-1:0]  pat_sum_s;

  assign fs_acc_s = LOCK_EN & frame_start;
  assign run_s    = (state_r == ST_RUN);
  assign h_act_s  = (h_cnt_r >= H_ACT_B) && (h_cnt_r < H_ACT_E);
  assign v_act_s  = (v_cnt_r >= V_ACT_B) && (v_cnt_r < V_ACT_E);
  assign hs0_s    = run_s && (h_cnt_r < H_SYNC_E);
  assign vs0_s    = run_s && (v_cnt_r < V_SYNC_E);
  assign de0_s    = run_s && h_act_s && v_act_s;
  assign x0_s     = h_cnt_r - H_ACT_B;
  assign y0_s     = v_cnt_r - V_ACT_B;
  assign locked   = run_s;

  // Gating with reset keeps the FIFO untouched while the pipeline is being cleared.
  assign fifo_rd_en = de0_s & ~pattern_en & ~fifo_empty & ~video_rst;

  // Lock state machine and stage-0 counter next-state.
  always_comb begin
    state_s   = state_r;
    h_cnt_s   = h_cnt_r;
    v_cnt_s   = v_cnt_r;
    dly_cnt_s = dly_cnt_r;
    case (state_r)
      ST_IDLE: begin
        h_cnt_s   = CNT_ZERO;
        v_cnt_s   = CNT_ZERO;
        dly_cnt_s = DLY_ZERO;
        if (fs_acc_s) begin
          state_s = (LOCK_DELAY == 0) ? ST_RUN : ST_DELAY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DELAY: begin
        h_cnt_s = CNT_ZERO;
        v_cnt_s = CNT_ZERO;
        if (fs_acc_s) begin
          dly_cnt_s = DLY_ZERO;
        end else if (dly_cnt_r == DLY_LAST) begin
          dly_cnt_s = DLY_ZERO;
          state_s   = ST_RUN;
        end else begin
          dly_cnt_s = dly_cnt_r + DLY_ONE;
        end
      end
      ST_RUN: begin
        if (fs_acc_s) begin
          // Re-lock truncates the current frame.
          h_cnt_s   = CNT_ZERO;
          v_cnt_s   = CNT_ZERO;
          dly_cnt_s = DLY_ZERO;
          state_s   = (LOCK_DELAY == 0) ? ST_RUN : ST_DELAY;
        end else if (h_cnt_r == H_LAST) begin
          h_cnt_s = CNT_ZERO;
          v_cnt_s = (v_cnt_r == V_LAST) ? CNT_ZERO : v_cnt_r + CNT_ONE;
        end else begin
          h_cnt_s = h_cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s   = ST_RESET;
        h_cnt_s   = CNT_ZERO;
        v_cnt_s   = CNT_ZERO;
        dly_cnt_s = DLY_ZERO;
      end
    endcase
  end

  // Stage-0 state register.
  always_ff @(posedge video_clk) begin
    if (video_rst) begin
      state_r   <= ST_RESET;
      h_cnt_r   <= CNT_ZERO;
      v_cnt_r   <= CNT_ZERO;
      dly_cnt_r <= DLY_ZERO;
    end else begin
      state_r   <= state_s;
      h_cnt_r   <= h_cnt_s;
      v_cnt_r   <= v_cnt_s;
      dly_cnt_r <= dly_cnt_s;
    end
  end

  // Stage-1 registers: timing outputs, coordinates, pixel source and sticky underflow.
  always_ff @(posedge video_clk) begin
    if (video_rst) begin
      hs        <= ~HS_POL;
      vs        <= ~VS_POL;
      de        <= 1'b0;
      x         <= CNT_ZERO;
      y         <= CNT_ZERO;
      pat_r     <= 1'b0;
      rd_r      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      hs    <= hs0_s ? HS_POL : ~HS_POL;
      vs    <= vs0_s ? VS_POL : ~VS_POL;
      de    <= de0_s;
      x     <= de0_s ? x0_s : CNT_ZERO;
      y     <= de0_s ? y0_s : CNT_ZERO;
      pat_r <= de0_s & pattern_en;
      rd_r  <= fifo_rd_en;
      if (de0_s && !pattern_en && fifo_empty) begin
        underflow <= 1'b1;
      end else if (fs_acc_s) begin
        underflow <= 1'b0;
      end else begin
        underflow <= underflow;
      end
    end
  end

  assign pat_sum_s = SUM_W'(x) + SUM_W'(y);

  // FIFO data arrives one cycle after the read, so the pixel mux sits after the stage-1 flops.
  always_comb begin
    vout_data = PIX_ZERO;
    if (de) begin
      if (pat_r) begin
        vout_data = pat_sum_s[DATA_WIDTH-1:0];
      end else if (rd_r) begin
        vout_data = fifo_q;
      end else begin
        vout_data = FILL_COLOR;
      end
    end else begin
      vout_data = PIX_ZERO;
    end
  end

endmodule
